// File: rtl/i2c_target.sv
// I2C target (slave) with a fixed 7-bit address, byte-wide write/read handshakes
// to local logic, oversampled on a single system clock.
module i2c_target #(
  parameter logic [6:0] TARGET_ADDR = 7'h42,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       axi_aclk,
  input  logic       axi_aresetn,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_req,
  output logic       busy,
  output logic       nack_seen,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ADDR      = 3'd1,
    S_ADDR_ACK  = 3'd2,
    S_WRITE     = 3'd3,
    S_WR_ACK    = 3'd4,
    S_READ      = 3'd5,
    S_RD_ACK    = 3'd6,
    S_WAIT_STOP = 3'd7
  } state_t;

  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic scl_d, sda_d, scl_s, sda_s;
  logic start_det, stop_det, scl_rise, scl_fall;

  // Synchronisers reset to 1 so a reset looks like an idle bus, not a START.
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_in};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
      scl_d    <= scl_s;
      sda_d    <= sda_s;
    end
  end

  assign scl_s     = scl_sync[SYNC_STAGES-1];
  assign sda_s     = sda_sync[SYNC_STAGES-1];
  assign start_det = scl_s & scl_d & sda_d & ~sda_s;
  assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;
  assign scl_rise  = scl_s & ~scl_d;
  assign scl_fall  = ~scl_s & scl_d;

  state_t     cur_state, nxt_state;
  logic [2:0] bit_cnt, cnt_n;
  logic [7:0] shreg, shreg_n, shift_in, rxd_n;
  logic       rw_bit, rw_n, ld_pend, ld_n;
  logic       oe_n, rxv_n, txr_n, busy_n, nack_n;

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      cur_state <= S_IDLE;
      bit_cnt   <= '0;
      shreg     <= '0;
      rw_bit    <= 1'b0;
      ld_pend   <= 1'b0;
      sda_oe    <= 1'b0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      tx_req    <= 1'b0;
      busy      <= 1'b0;
      nack_seen <= 1'b0;
    end else begin
      cur_state <= nxt_state;
      bit_cnt   <= cnt_n;
      shreg     <= shreg_n;
      rw_bit    <= rw_n;
      ld_pend   <= ld_n;
      sda_oe    <= oe_n;
      rx_data   <= rxd_n;
      rx_valid  <= rxv_n;
      tx_req    <= txr_n;
      busy      <= busy_n;
      nack_seen <= nack_n;
    end
  end

  assign shift_in = {shreg[6:0], sda_s};

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    nxt_state = cur_state;
    cnt_n     = bit_cnt;
    shreg_n   = shreg;
    rw_n      = rw_bit;
    ld_n      = ld_pend;
    oe_n      = sda_oe;
    rxd_n     = rx_data;
    rxv_n     = 1'b0;
    txr_n     = 1'b0;
    busy_n    = busy;
    nack_n    = nack_seen;

    if (stop_det) begin
      nxt_state = S_IDLE;
      oe_n      = 1'b0;
      busy_n    = 1'b0;
      ld_n      = 1'b0;
      cnt_n     = '0;
    end else if (start_det) begin
      // busy is left alone so it stays high across a repeated START.
      nxt_state = S_ADDR;
      cnt_n     = '0;
      shreg_n   = '0;
      oe_n      = 1'b0;
      ld_n      = 1'b0;
    end else begin
      case (cur_state)
        S_ADDR: if (scl_rise) begin
          shreg_n = shift_in;
          cnt_n   = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            if (shreg[6:0] == TARGET_ADDR) begin
              nxt_state = S_ADDR_ACK;
              busy_n    = 1'b1;
              nack_n    = 1'b0;
              rw_n      = sda_s;
              txr_n     = sda_s;
            end else begin
              nxt_state = S_WAIT_STOP;
              busy_n    = 1'b0;
            end
          end
        end

        // sda_oe doubles as the ACK phase: first fall drives, second fall releases.
        S_ADDR_ACK, S_WR_ACK: if (scl_fall) begin
          if (!sda_oe) begin
            oe_n = 1'b1;
          end else if (cur_state == S_ADDR_ACK && rw_bit) begin
            nxt_state = S_READ;
            shreg_n   = tx_data;
            oe_n      = ~tx_data[7];
          end else begin
            nxt_state = S_WRITE;
            oe_n      = 1'b0;
          end
        end

        S_WRITE: if (scl_rise) begin
          shreg_n = shift_in;
          cnt_n   = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            rxd_n     = shift_in;
            rxv_n     = 1'b1;
            nxt_state = S_WR_ACK;
          end
        end

        S_READ: begin
          if (scl_rise && !ld_pend) begin
            cnt_n = bit_cnt + 3'd1;
          end else if (scl_fall) begin
            if (ld_pend) begin
              ld_n    = 1'b0;
              shreg_n = tx_data;
              oe_n    = ~tx_data[7];
            end else if (bit_cnt == 3'd0) begin
              oe_n      = 1'b0;
              nxt_state = S_RD_ACK;
            end else begin
              shreg_n = {shreg[6:0], 1'b0};
              oe_n    = ~shreg[6];
            end
          end
        end

        S_RD_ACK: if (scl_rise) begin
          if (!sda_s) begin
            nxt_state = S_READ;
            ld_n      = 1'b1;
            txr_n     = 1'b1;
          end else begin
            nack_n    = 1'b1;
            nxt_state = S_WAIT_STOP;
            oe_n      = 1'b0;
          end
        end

        default: ;
      endcase
    end
  end

  assign state = cur_state;

endmodule

// File: tb/tb_i2c_target.sv
// Self-checking bench for i2c_target: directed bus scenarios plus randomized
// transactions scored against a transaction-level model of the target.
module tb_i2c_target;

  localparam logic [6:0] TGT = 7'h42;
  localparam int Q = 4;  // quarter SCL period in system clocks

  logic       axi_aclk = 1'b0;
  logic       axi_aresetn = 1'b0;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_bus;
  logic       sda_oe;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data = 8'h00;
  logic       tx_req;
  logic       busy;
  logic       nack_seen;
  logic [2:0] state;

  int total = 0;
  int bad = 0;
  int rxv_cnt = 0;
  int txr_cnt = 0;
  logic [7:0] rx_got[$];
  logic [7:0] tx_q[$];
  logic [7:0] data_q[$];
  logic       exp_busy = 1'b0;
  logic       exp_nack = 1'b0;

  assign sda_bus = sda_m & ~sda_oe;

  i2c_target #(.TARGET_ADDR(TGT), .SYNC_STAGES(2)) dut (
    .axi_aclk   (axi_aclk),
    .axi_aresetn(axi_aresetn),
    .scl_in     (scl_m),
    .sda_in     (sda_bus),
    .sda_oe     (sda_oe),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .tx_data    (tx_data),
    .tx_req     (tx_req),
    .busy       (busy),
    .nack_seen  (nack_seen),
    .state      (state)
  );

  always #5 axi_aclk = ~axi_aclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge axi_aclk);
  endtask

  // One SCL period starting and ending with SCL low; returns the bus level mid-high.
  task automatic bit_cycle(input logic b, output logic rd);
    clks(Q); sda_m = b;
    clks(Q); scl_m = 1'b1;
    clks(Q); rd = sda_bus;
    clks(Q); scl_m = 1'b0;
  endtask

  task automatic start_cond();
    if (!scl_m) begin
      clks(Q); sda_m = 1'b1;
      clks(Q); scl_m = 1'b1;
    end
    clks(Q); sda_m = 1'b0;
    clks(Q); scl_m = 1'b0;
  endtask

  task automatic stop_cond();
    clks(Q); sda_m = 1'b0;
    clks(Q); scl_m = 1'b1;
    clks(Q); sda_m = 1'b1;
    clks(2*Q);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) bit_cycle(b[i], r);
    bit_cycle(1'b1, r);
    ack = ~r;
  endtask

  task automatic read_byte(input logic give_ack, output logic [7:0] d);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      bit_cycle(1'b1, r);
      d[i] = r;
    end
    bit_cycle(~give_ack, r);
  endtask

  // Monitor: records rx_valid bytes and serves queued tx_data on each tx_req.
  initial begin
    forever begin
      @(posedge axi_aclk);
      #1;
      if (rx_valid) begin
        rx_got.push_back(rx_data);
        rxv_cnt++;
      end
      if (tx_req) begin
        txr_cnt++;
        if (tx_q.size() > 0) tx_data = tx_q.pop_front();
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Transaction-level model: an address hit ACKs every byte; writes deliver each
  // byte on rx_valid; reads return the queued tx bytes in order, last one NACKed.
  task automatic txn(input logic [7:0] addr, input logic do_stop);
    logic       ack, hit, rd;
    logic [7:0] d;
    logic [7:0] exp_rx[$];
    int n, rx0, tx0;
    n   = data_q.size();
    hit = (addr[7:1] == TGT);
    rd  = addr[0];
    rx0 = rxv_cnt;
    tx0 = txr_cnt;
    rx_got.delete();
    if (hit && rd) foreach (data_q[i]) tx_q.push_back(data_q[i]);
    start_cond();
    check("busy_at_start", busy, exp_busy);
    write_byte(addr, ack);
    check("addr_ack", ack, hit);
    if (hit) begin
      exp_busy = 1'b1;
      exp_nack = 1'b0;
    end else begin
      exp_busy = 1'b0;
      check("state_wait_stop", state, 3'd7);
    end
    check("busy_after_addr", busy, exp_busy);
    for (int k = 0; k < n; k++) begin
      if (hit && rd) begin
        read_byte(k < n - 1, d);
        check("rd_byte", d, data_q[k]);
      end else begin
        write_byte(data_q[k], ack);
        check("wr_ack", ack, hit);
        if (hit) exp_rx.push_back(data_q[k]);
      end
    end
    if (hit && rd) exp_nack = 1'b1;
    if (!hit) check("state_still_wait", state, 3'd7);
    if (do_stop) begin
      stop_cond();
      exp_busy = 1'b0;
      check("busy_after_stop", busy, 1'b0);
      check("state_idle", state, 3'd0);
      check("sda_released", sda_oe, 1'b0);
    end
    check("nack_seen", nack_seen, exp_nack);
    check("rx_count", rxv_cnt - rx0, exp_rx.size());
    if (rx_got.size() == exp_rx.size())
      foreach (exp_rx[i]) check("rx_byte", rx_got[i], exp_rx[i]);
    check("tx_req_count", txr_cnt - tx0, (hit && rd) ? n : 0);
    tx_q.delete();
  endtask

  initial begin
    logic       ack, r;
    logic [7:0] v;
    int         rx0;

    clks(3);
    check("rst_sda_oe", sda_oe, 1'b0);
    check("rst_state", state, 3'd0);
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_rx_valid", rx_valid, 1'b0);
    check("rst_tx_req", tx_req, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_nack", nack_seen, 1'b0);
    axi_aresetn = 1'b1;
    clks(4);

    data_q = '{8'hA5, 8'h3C};
    txn(8'h84, 1'b1);

    data_q = '{8'hFF};
    txn(8'h86, 1'b1);

    data_q = '{8'h5A, 8'hC3};
    txn(8'h85, 1'b1);

    // Repeated START between a write and a read.
    data_q = '{8'h11};
    txn(8'h84, 1'b0);
    check("sr_rx_data", rx_data, 8'h11);
    data_q = '{8'($urandom)};
    txn(8'h85, 1'b1);
    check("sr_rx_hold", rx_data, 8'h11);

    // Reset while the target is pulling SDA low during a read byte.
    v = 8'($urandom_range(0, 127));
    tx_q.push_back(v);
    start_cond();
    write_byte(8'h85, ack);
    check("rst_rd_addr_ack", ack, 1'b1);
    clks(Q);
    check("rst_rd_drive", sda_oe, 1'b1);
    #3 axi_aresetn = 1'b0;
    #1;
    check("async_sda_oe", sda_oe, 1'b0);
    check("async_state", state, 3'd0);
    check("async_busy", busy, 1'b0);
    check("async_rx_data", rx_data, 8'h00);
    check("async_rx_valid", rx_valid, 1'b0);
    check("async_tx_req", tx_req, 1'b0);
    check("async_nack", nack_seen, 1'b0);
    sda_m = 1'b1;
    scl_m = 1'b1;
    clks(4);
    axi_aresetn = 1'b1;
    clks(4);
    tx_q.delete();
    exp_busy = 1'b0;
    exp_nack = 1'b0;
    data_q = '{8'($urandom)};
    txn(8'h84, 1'b1);

    // STOP in the middle of a data byte.
    start_cond();
    write_byte(8'h84, ack);
    check("mid_addr_ack", ack, 1'b1);
    rx0 = rxv_cnt;
    for (int i = 0; i < 4; i++) bit_cycle(1'($urandom_range(0, 1)), r);
    stop_cond();
    exp_busy = 1'b0;
    exp_nack = 1'b0;
    check("mid_no_rx", rxv_cnt - rx0, 0);
    check("mid_state", state, 3'd0);
    check("mid_sda_oe", sda_oe, 1'b0);
    check("mid_busy", busy, 1'b0);

    for (int t = 0; t < 6; t++) begin
      logic [6:0] a7;
      int         nb;
      a7 = ($urandom_range(0, 2) != 0) ? TGT : 7'($urandom_range(0, 127));
      nb = $urandom_range(1, 3);
      data_q.delete();
      for (int k = 0; k < nb; k++) data_q.push_back(8'($urandom));
      txn({a7, 1'($urandom_range(0, 1))}, 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
